// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter sharing one synchronous FIFO between NUM_REQ producers.
// Each grant allows at most BURST_LEN accepted beats; consumer pops pass straight through.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 32,
    parameter int BURST_LEN  = 4,
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          pop_req,
    output logic                          pop_ack,
    input  logic                          fifo_full,
    input  logic                          fifo_empty,
    output logic                          fifo_cs,
    output logic                          fifo_wr_en,
    output logic                          fifo_rd_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic                          busy,
    output logic [OW-1:0]                 owner_id
);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d, search_owner;
    logic [CW-1:0]       beat_q, beat_d;
    logic [NUM_REQ-1:0]  owner_onehot;
    logic [FIFO_WIDTH-1:0] lane_data;
    logic                own_valid;
    logic                wr_fire;

    // Lowest offset after the last owner wins; the last owner itself is tried last.
    always_comb begin
        logic [OW-1:0] idx;
        idx          = '0;
        search_owner = owner_q;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = OW'((int'(owner_q) + i) % NUM_REQ);
            if (req_valid[idx]) search_owner = idx;
        end
    end

    always_comb begin
        owner_onehot = '0;
        lane_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_onehot[i] = (owner_q == OW'(i));
            if (owner_q == OW'(i)) lane_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

    assign busy      = (state_q == GRANT);
    assign own_valid = |(req_valid & owner_onehot);
    assign wr_fire   = busy && own_valid && !fifo_full;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    owner_d = search_owner;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!own_valid) begin
                    state_d = IDLE;
                end else if (wr_fire) begin
                    beat_d = beat_q + CW'(1);
                    if (beat_q == LAST_BEAT) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OW'(NUM_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
        end
    end

    // The read path and owner index are gated by rst_n so every output reads 0 during reset.
    assign req_ready    = (busy && !fifo_full) ? owner_onehot : '0;
    assign fifo_wr_en   = wr_fire;
    assign fifo_data_in = busy ? lane_data : '0;
    assign fifo_rd_en   = rst_n && pop_req && !fifo_empty;
    assign pop_ack      = fifo_rd_en;
    assign fifo_cs      = fifo_wr_en || fifo_rd_en;
    assign owner_id     = rst_n ? owner_q : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// compared against a rule-level behavioural model.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int W       = 32;
    localparam int BL      = 4;
    localparam int OW      = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*W-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   pop_req, pop_ack;
    logic                   fifo_full, fifo_empty;
    logic                   fifo_cs, fifo_wr_en, fifo_rd_en;
    logic [W-1:0]           fifo_data_in;
    logic                   busy;
    logic [OW-1:0]          owner_id;

    int vectors = 0;
    int miscompares = 0;

    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(W), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .pop_req(pop_req), .pop_ack(pop_ack),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_cs(fifo_cs),
        .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_data_in(fifo_data_in),
        .busy(busy), .owner_id(owner_id)
    );

    always #5 clk = ~clk;

    // Reference model: granted flag, owner lane and beats accepted in this grant.
    logic m_grant = 1'b0;
    int   m_owner = NUM_REQ - 1;
    int   m_beats = 0;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        logic [OW-1:0] k;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = OW'((last + i) % NUM_REQ);
            if (v[k]) return (last + i) % NUM_REQ;
        end
        return last;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_grant <= 1'b0;
            m_owner <= NUM_REQ - 1;
            m_beats <= 0;
        end else if (!m_grant) begin
            if (|req_valid) begin
                m_owner <= rr_pick(req_valid, m_owner);
                m_beats <= 0;
                m_grant <= 1'b1;
            end
        end else if (!req_valid[OW'(m_owner)]) begin
            m_grant <= 1'b0;
        end else if (!fifo_full) begin
            if (m_beats + 1 == BL) m_grant <= 1'b0;
            m_beats <= m_beats + 1;
        end
    end

    task automatic set_lane(input int i, input logic [W-1:0] v);
        logic [NUM_REQ*W-1:0] m;
        m = {{((NUM_REQ-1)*W){1'b0}}, {W{1'b1}}} << (i*W);
        req_data = (req_data & ~m) | ((NUM_REQ*W)'(v) << (i*W));
    endtask

    task automatic do_reset;
        rst_n = 1'b0; req_valid = '0; pop_req = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = '1; pop_req = 1'b1; fifo_empty = 1'b0; fifo_full = 1'b0;
        req_data = {NUM_REQ{32'hDEADBEEF}};
        @(posedge clk); #2;
        vectors++;
        if ({req_ready, fifo_cs, fifo_wr_en, fifo_rd_en, pop_ack, busy} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0", {req_ready, fifo_cs, fifo_wr_en, fifo_rd_en, pop_ack, busy});
        end
        vectors++;
        if (owner_id !== 2'd0 || fifo_data_in !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_owner_data: got %0d/%h expected 0/0", owner_id, fifo_data_in);
        end
        req_valid = '0; pop_req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1; #1;
        vectors++;
        if (owner_id !== 2'd3 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got owner %0d busy %b expected 3/0", owner_id, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_producer;
        int k = 0;
        int bad_owner = 0;
        logic [15:0] wmask = '0;
        do_reset;
        for (int c = 0; c < 12; c++) begin
            req_valid = (k < 6) ? 4'b0100 : 4'b0000;
            set_lane(2, 32'hA0 + 32'(k));
            @(negedge clk);
            if (fifo_wr_en) begin
                wmask = wmask | (16'd1 << c);
                vectors++;
                if (fifo_data_in !== 32'hA0 + 32'(k)) begin
                    miscompares++;
                    $display("FAIL single_data: got %h expected %h", fifo_data_in, 32'hA0 + 32'(k));
                end
                k++;
            end
            if (busy && owner_id !== 2'd2) bad_owner++;
            @(posedge clk); #1;
        end
        vectors++;
        if (wmask !== 16'h00DE) begin
            miscompares++;
            $display("FAIL single_wr_cycles: got %h expected 00de", wmask);
        end
        vectors++;
        if (bad_owner != 0 || k != 6) begin
            miscompares++;
            $display("FAIL single_owner_count: got bad_owner %0d writes %0d expected 0/6", bad_owner, k);
        end
    endtask

    task automatic test_round_robin;
        int seq[NUM_REQ] = '{default: 0};
        int owners[$];
        int beats[$];
        int exp_owner[6] = '{0, 1, 3, 0, 1, 3};
        int ready2 = 0, rd_cnt = 0;
        logic prev_busy = 1'b0;
        logic [W-1:0] exp_d;
        do_reset;
        pop_req = 1'b1; fifo_empty = 1'b0; req_valid = 4'b1011;
        for (int c = 0; c < 32; c++) begin
            for (int l = 0; l < NUM_REQ; l++) set_lane(l, (32'(l) << 28) | 32'(seq[l]));
            @(negedge clk);
            if (busy && !prev_busy) begin
                owners.push_back(int'(owner_id));
                beats.push_back(0);
            end
            if (fifo_wr_en && beats.size() > 0) begin
                beats[beats.size()-1]++;
                exp_d = (32'(owner_id) << 28) | 32'(seq[owner_id]);
                vectors++;
                if (fifo_data_in !== exp_d) begin
                    miscompares++;
                    $display("FAIL rr_data: got %h expected %h", fifo_data_in, exp_d);
                end
                seq[owner_id]++;
            end
            if (req_ready[2]) ready2++;
            if (fifo_rd_en && pop_ack) rd_cnt++;
            prev_busy = busy;
            @(posedge clk); #1;
        end
        for (int g = 0; g < 6; g++) begin
            vectors++;
            if (g >= owners.size()) begin
                miscompares++;
                $display("FAIL rr_grant_missing: got %0d grants expected at least %0d", owners.size(), g + 1);
            end else if (owners[g] != exp_owner[g] || beats[g] != BL) begin
                miscompares++;
                $display("FAIL rr_grant: got owner %0d beats %0d expected %0d/%0d", owners[g], beats[g], exp_owner[g], BL);
            end
        end
        vectors++;
        if (ready2 != 0 || rd_cnt != 32) begin
            miscompares++;
            $display("FAIL rr_lane2_reads: got ready2 %0d reads %0d expected 0/32", ready2, rd_cnt);
        end
        req_valid = '0; pop_req = 1'b0;
    endtask

    task automatic test_backpressure;
        int w = 0, fc = 0, rel_w = -1;
        logic prev_busy = 1'b0;
        do_reset;
        fifo_empty = 1'b0; req_valid = 4'b0010;
        for (int c = 0; c < 12; c++) begin
            fifo_full = (w == 1 && fc < 5);
            set_lane(1, 32'h1000 + 32'(w));
            @(negedge clk);
            if (fifo_full) begin
                fc++;
                vectors++;
                if ({req_ready, fifo_wr_en, busy, owner_id} !== {4'b0000, 1'b0, 1'b1, 2'd1}) begin
                    miscompares++;
                    $display("FAIL bp_hold: got %b expected 0000_0_1_01", {req_ready, fifo_wr_en, busy, owner_id});
                end
            end
            if (fifo_wr_en) begin
                vectors++;
                if (fifo_data_in !== 32'h1000 + 32'(w)) begin
                    miscompares++;
                    $display("FAIL bp_data: got %h expected %h", fifo_data_in, 32'h1000 + 32'(w));
                end
                w++;
            end
            if (prev_busy && !busy && rel_w < 0) rel_w = w;
            prev_busy = busy;
            @(posedge clk); #1;
        end
        fifo_full = 1'b0; req_valid = '0;
        vectors++;
        if (fc != 5 || rel_w != BL) begin
            miscompares++;
            $display("FAIL bp_burst: got full cycles %0d beats %0d expected 5/%0d", fc, rel_w, BL);
        end
    endtask

    task automatic test_owner_yield;
        int w0 = 0, w3 = 0;
        logic bb[10];
        logic ww[10];
        int oo[10];
        do_reset;
        for (int c = 0; c < 10; c++) begin
            req_valid = {1'b1, 2'b00, (w0 < 2)};
            set_lane(0, 32'h0E00 + 32'(w0));
            set_lane(3, 32'h3E00 + 32'(w3));
            @(negedge clk);
            bb[c] = busy; ww[c] = fifo_wr_en; oo[c] = int'(owner_id);
            if (fifo_wr_en && owner_id == 2'd0) w0++;
            if (fifo_wr_en && owner_id == 2'd3 && c >= 5 && c <= 8) w3++;
            @(posedge clk); #1;
        end
        req_valid = '0;
        vectors++;
        if (bb[3] !== 1'b1 || ww[3] !== 1'b0 || oo[3] != 0) begin
            miscompares++;
            $display("FAIL yield_drop: got busy %b wr %b owner %0d expected 1/0/0", bb[3], ww[3], oo[3]);
        end
        vectors++;
        if (bb[4] !== 1'b0 || bb[5] !== 1'b1 || oo[5] != 3) begin
            miscompares++;
            $display("FAIL yield_regrant: got busy %b%b owner %0d expected 01/3", bb[4], bb[5], oo[5]);
        end
        vectors++;
        if (w3 != BL || bb[9] !== 1'b0 || w0 != 2) begin
            miscompares++;
            $display("FAIL yield_beats: got lane3 %0d lane0 %0d idle %b expected %0d/2/0", w3, w0, bb[9], BL);
        end
    endtask

    task automatic test_concurrent_rw;
        do_reset;
        req_valid = 4'b0010; set_lane(1, 32'h55); pop_req = 1'b1; fifo_empty = 1'b0;
        @(negedge clk);
        vectors++;
        if ({fifo_cs, fifo_wr_en, fifo_rd_en, pop_ack} !== 4'b1011) begin
            miscompares++;
            $display("FAIL crw_idle_read: got %b expected 1011", {fifo_cs, fifo_wr_en, fifo_rd_en, pop_ack});
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if ({fifo_cs, fifo_wr_en, fifo_rd_en, pop_ack} !== 4'b1111) begin
            miscompares++;
            $display("FAIL crw_both: got %b expected 1111", {fifo_cs, fifo_wr_en, fifo_rd_en, pop_ack});
        end
        @(posedge clk); #1;
        fifo_empty = 1'b1;
        @(negedge clk);
        vectors++;
        if ({fifo_cs, fifo_wr_en, fifo_rd_en, pop_ack} !== 4'b1100) begin
            miscompares++;
            $display("FAIL crw_empty: got %b expected 1100", {fifo_cs, fifo_wr_en, fifo_rd_en, pop_ack});
        end
        @(posedge clk); #1;
        req_valid = '0; pop_req = 1'b0;
    endtask

    task automatic test_async_reset;
        do_reset;
        req_valid = 4'b1000; set_lane(3, 32'h3333); pop_req = 1'b1; fifo_empty = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if ({busy, owner_id, fifo_wr_en} !== {1'b1, 2'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL areset_pre: got %b expected 1_11_1", {busy, owner_id, fifo_wr_en});
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({req_ready, fifo_cs, fifo_wr_en, fifo_rd_en, pop_ack, busy, owner_id} !== 11'b0 || fifo_data_in !== 32'h0) begin
            miscompares++;
            $display("FAIL areset_outputs: got %b data %h expected 0/0",
                     {req_ready, fifo_cs, fifo_wr_en, fifo_rd_en, pop_ack, busy, owner_id}, fifo_data_in);
        end
        req_valid = 4'b1010; pop_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b1 || owner_id !== 2'd1) begin
            miscompares++;
            $display("FAIL areset_restart: got busy %b owner %0d expected 1/1", busy, owner_id);
        end
        req_valid = '0;
    endtask

    task automatic test_random;
        logic [NUM_REQ-1:0] exp_ready;
        logic exp_wr, exp_rd;
        logic [W-1:0] exp_data;
        do_reset;
        for (int c = 0; c < 400; c++) begin
            req_valid  = 4'($urandom) | 4'($urandom);
            for (int l = 0; l < NUM_REQ; l++) set_lane(l, $urandom);
            fifo_full  = ($urandom_range(0, 4) == 0);
            fifo_empty = ($urandom_range(0, 3) == 0);
            pop_req    = 1'($urandom);
            @(negedge clk);
            exp_ready = (m_grant && !fifo_full) ? (4'b0001 << m_owner) : 4'b0000;
            exp_wr    = m_grant && req_valid[OW'(m_owner)] && !fifo_full;
            exp_rd    = pop_req && !fifo_empty;
            exp_data  = m_grant ? W'(req_data >> (m_owner * W)) : '0;
            vectors++;
            if ({busy, owner_id, req_ready, fifo_wr_en, fifo_rd_en, pop_ack, fifo_cs} !==
                {m_grant, OW'(m_owner), exp_ready, exp_wr, exp_rd, exp_rd, exp_wr | exp_rd}) begin
                miscompares++;
                $display("FAIL rand_ctrl cycle %0d: got %b expected %b", c,
                         {busy, owner_id, req_ready, fifo_wr_en, fifo_rd_en, pop_ack, fifo_cs},
                         {m_grant, OW'(m_owner), exp_ready, exp_wr, exp_rd, exp_rd, exp_wr | exp_rd});
            end
            vectors++;
            if (fifo_data_in !== exp_data) begin
                miscompares++;
                $display("FAIL rand_data cycle %0d: got %h expected %h", c, fifo_data_in, exp_data);
            end
            @(posedge clk); #1;
        end
        req_valid = '0; pop_req = 1'b0; fifo_full = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; pop_req = 1'b0;
        fifo_full = 1'b0; fifo_empty = 1'b1;
        test_reset;
        test_single_producer;
        test_round_robin;
        test_backpressure;
        test_owner_yield;
        test_concurrent_rw;
        test_async_reset;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
